// File: rtl/addsub_serial_pkg.sv
// Shared constants and state type for the digit-serial adder/subtractor.
package addsub_serial_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co       = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with start/done handshake.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NDIG - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dsum;
  logic             dco, dcmsb;
  logic [WIDTH-1:0] r_next;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x       (a_q[DIGIT-1:0]),
    .y       (b_q[DIGIT-1:0]),
    .ci      (carry_q),
    .s       (dsum),
    .co      (dco),
    .c_msb_in(dcmsb)
  );

  // New digit enters at the top; after NDIG digits the LSB digit sits at bit 0.
  assign r_next = (r_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
            a_q     <= a;
            b_q     <= (sel == SEL_SUB) ? ~b : b;
            carry_q <= (sel == SEL_SUB) ? ~cin : cin;
            cnt_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          r_q     <= r_next;
          carry_q <= dco;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= r_next;
            cout    <= dco;
            // Carry into MSB differing from carry out means signed overflow.
            ovf     <= dcmsb ^ dco;
            zero    <= (r_next == '0);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench: 8-bit/2-digit and 4-bit/1-digit instances against an arithmetic model.
module tb_addsub_serial;

  typedef struct {
    int sum;
    int cout;
    int ovf;
    int zero;
    int acc;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic       start8 = 1'b0, sel8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8, zero8;
  logic [7:0] sum8;

  logic       start4 = 1'b0, sel4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4, zero4;
  logic [3:0] sum4;

  int   n_vec = 0;
  int   n_fail = 0;
  int   last_due = 0;
  int   last_sum[2] = '{0, 0};
  exp_t q8[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  addsub_serial #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sel(sel4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the mathematical values.
  function automatic exp_t model(input int w, input int a, input int b, input bit s, input bit c);
    exp_t e;
    int m, r, sa, sb, sr;
    m  = 1 << w;
    a  = a & (m - 1);
    b  = b & (m - 1);
    r  = s ? (a - b - int'(c)) : (a + b + int'(c));
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = s ? (sa - sb - int'(c)) : (sa + sb + int'(c));
    e.sum  = ((r % m) + m) % m;
    e.cout = s ? int'(r >= 0) : int'(r >= m);
    e.ovf  = int'(sr < -(m / 2) || sr > (m / 2 - 1));
    e.zero = int'(e.sum == 0);
    e.acc  = 0;
    e.due  = 0;
    return e;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q8.size() : q4.size();
  endfunction

  function automatic exp_t qfront(input int d);
    return (d == 0) ? q8[0] : q4[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q8.pop_front());
    else void'(q4.pop_front());
  endtask

  task automatic drive(input int d, input int a, input int b, input bit s, input bit c,
                       input bit st);
    if (d == 0) begin
      a8 = a[7:0]; b8 = b[7:0]; sel8 = s; cin8 = c; start8 = st;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; sel4 = s; cin4 = c; start4 = st;
    end
  endtask

  task automatic mon(input int d, input logic busy, input logic done, input int sum,
                     input logic cout, input logic ovf, input logic zero);
    exp_t f;
    int   n;
    bit   eb, ed;
    f  = '{default: 0};
    n  = qsize(d);
    if (n > 0) f = qfront(d);
    eb = (n > 0) && (cyc >= f.acc) && (cyc < f.due);
    ed = (n > 0) && (cyc >= f.due);
    check($sformatf("busy[%0d]", d), int'(busy), int'(eb));
    check($sformatf("done[%0d]", d), int'(done), int'(ed));
    if (done && n > 0) begin
      check($sformatf("latency[%0d]", d), cyc, f.due);
      check($sformatf("sum[%0d]", d), sum, f.sum);
      check($sformatf("cout[%0d]", d), int'(cout), f.cout);
      check($sformatf("ovf[%0d]", d), int'(ovf), f.ovf);
      check($sformatf("zero[%0d]", d), int'(zero), f.zero);
      last_sum[d] = f.sum;
    end else if (!done) begin
      check($sformatf("sum_hold[%0d]", d), sum, last_sum[d]);
    end
    if (ed) qpop(d);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, busy8, done8, int'(sum8), cout8, ovf8, zero8);
      mon(1, busy4, done4, int'(sum4), cout4, ovf4, zero4);
    end
  end

  // Start one operation on the next edge; optionally keep start high for a back-to-back op.
  task automatic issue(input int d, input int a, input int b, input bit s, input bit c,
                       input bit hold);
    exp_t e;
    @(negedge clk);
    drive(d, a, b, s, c, 1'b1);
    @(posedge clk);
    #1;
    e = model((d == 0) ? 8 : 4, a, b, s, c);
    e.acc = cyc;
    e.due = cyc + 4;
    if (d == 0) q8.push_back(e);
    else q4.push_back(e);
    last_due = e.due;
    drive(d, $urandom, $urandom, 1'($urandom), 1'($urandom), hold);
    if (!hold) begin
      // Stray start pulse while running must be ignored.
      @(negedge clk);
      drive(d, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
      @(posedge clk);
      #1;
      drive(d, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic wait_empty(input int d);
    int k = 0;
    while (qsize(d) != 0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check($sformatf("done_timeout[%0d]", d), qsize(d), 0);
    if (d == 0) q8.delete();
    else q4.delete();
  endtask

  task automatic wait_until(input int n);
    int k = 0;
    while (cyc < n && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  int  da[5]   = '{5, 5, 0, 1, 127};
  int  db[5]   = '{1, 1, 0, 5, 1};
  bit  dsel[5] = '{0, 1, 1, 1, 0};
  int  dsum[5] = '{6, 4, 0, 'hFC, 'h80};
  int  dco[5]  = '{0, 1, 1, 0, 0};
  int  dov[5]  = '{0, 0, 0, 0, 1};
  int  la[4]   = '{5, 0, 2, 1};
  int  lb[4]   = '{1, 0, 2, 5};
  int  ladd[4] = '{6, 0, 4, 6};
  int  lsub[4] = '{4, 0, 0, 'hC};
  int  lco[4]  = '{1, 1, 1, 0};

  initial begin
    bit b2b, nb;
    repeat (2) @(negedge clk);
    check("rst_busy8", int'(busy8), 0);
    check("rst_done8", int'(done8), 0);
    check("rst_sum8", int'(sum8), 0);
    check("rst_flags8", int'({cout8, ovf8, zero8}), 0);
    check("rst_busy4", int'(busy4), 0);
    check("rst_sum4", int'(sum4), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      issue(0, da[i], db[i], dsel[i], 1'b0, 1'b0);
      wait_empty(0);
      check("dir_sum8", int'(sum8), dsum[i]);
      check("dir_cout8", int'(cout8), dco[i]);
      check("dir_ovf8", int'(ovf8), dov[i]);
      check("dir_zero8", int'(zero8), int'(dsum[i] == 0));
    end

    // Reset in the second RUN cycle aborts the operation.
    issue(0, 33, 44, 1'b0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy8", int'(busy8), 0);
    check("abort_done8", int'(done8), 0);
    check("abort_sum8", int'(sum8), 0);
    q8.delete();
    last_sum[0] = 0;
    last_sum[1] = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    issue(0, 100, 27, 1'b1, 1'b1, 1'b0);
    wait_empty(0);
    check("post_abort_sum8", int'(sum8), 72);

    // Back-to-back: start held through DONE.
    issue(0, 3, 4, 1'b0, 1'b0, 1'b1);
    wait_until(last_due);
    issue(0, 10, 20, 1'b1, 1'b0, 1'b0);
    wait_empty(0);
    check("b2b_sum8", int'(sum8), 'hF6);

    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nb = (i < 39) && ($urandom_range(0, 2) == 0);
      if (b2b) wait_until(last_due);
      else wait_empty(0);
      issue(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            1'($urandom), 1'($urandom), nb);
      b2b = nb;
    end
    wait_empty(0);

    for (int i = 0; i < 4; i++) begin
      issue(1, la[i], lb[i], 1'b0, 1'b0, 1'b0);
      wait_empty(1);
      check("legacy_add4", int'(sum4), ladd[i]);
      issue(1, la[i], lb[i], 1'b1, 1'b0, 1'b0);
      wait_empty(1);
      check("legacy_sub4", int'(sum4), lsub[i]);
      check("legacy_cout4", int'(cout4), lco[i]);
    end

    b2b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nb = (i < 19) && ($urandom_range(0, 2) == 0);
      if (b2b) wait_until(last_due);
      else wait_empty(1);
      issue(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            1'($urandom), 1'($urandom), nb);
      b2b = nb;
    end
    wait_empty(1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 30000", cyc);
    $fatal(1);
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
Parametrised, digit-serial two's-complement adder/subtractor with a start/done handshake. It generalises the 4-bit combinational add/sub unit to WIDTH bits. Each cycle it processes one DIGIT-wide slice, trading latency for area. Intended as the shared arithmetic engine for multi-cycle datapaths in the lab designs.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 2.
DIGIT, 2, bits processed per cycle; must divide WIDTH exactly; NDIG = WIDTH/DIGIT.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when not busy
sel  in  1  0 = add (a+b+cin), 1 = subtract (a-b-cin)
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B, captured on accepted start
cin  in  1  carry-in (add) / borrow-in (sub), captured on accepted start
busy  out  1  high while digits are being processed
done  out  1  one-cycle pulse when results are updated
sum  out  WIDTH  result, held until next completion
cout  out  1  raw carry out of MSB; in subtract, 1 = no borrow
ovf  out  1  signed overflow
zero  out  1  sum == 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy, done, sum, cout, ovf, zero = 0; internal shift registers and counter = 0.
- States are IDLE, RUN and DONE.
- IDLE or DONE with start=1 goes to RUN. On that edge:
  - capture a.
  - capture b, inverted when sel=1.
  - seed the carry register with cin when sel=0, or ~cin when sel=1.
  - clear the digit counter.
- DONE with start=0 goes to IDLE. This allows back-to-back operations with no idle cycle.
- RUN, each edge:
  - add the low DIGIT bits of the A and B registers and the carry.
  - shift the result digit into the top of the result register.
  - shift A and B right by DIGIT.
  - update the carry.
  - increment the counter.
- The digit processed when counter = NDIG-1 is the last. On that edge go to DONE, and register sum, cout, ovf and zero from the completed result.
- ovf = carry into MSB XOR carry out of MSB. Computed in the last digit as (a_msb ~^ b'_msb) & (a_msb ^ sum_msb), where b' is B after the subtract inversion.
- busy = (state == RUN). done = (state == DONE). Both are registered outputs.
- Latency: start accepted at edge 0; done high for the cycle following edge NDIG. busy is high during cycles 1..NDIG.
- start while RUN is ignored. a, b, sel and cin may change freely after acceptance.
- sum and flags change only on the edge entering DONE, and hold otherwise, including across IDLE.
- Reset asserted mid-RUN aborts immediately. Outputs clear, and no done is produced.
- DIGIT = WIDTH gives a single-cycle RUN (NDIG = 1). This is a legal configuration.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

Decomposition:
- Shared package holds:
  - the state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - the SEL_ADD and SEL_SUB constants.
- One sub-module is natural: digit_adder (parameter DIGIT). It is a combinational DIGIT-bit ripple adder with inputs x, y, ci and outputs s, co, and c_msb_in (carry into its top bit, used for ovf).
- The FSM, counter and shift registers stay in addsub_serial.

Test Plan:
- WIDTH=8, DIGIT=2: a=5, b=1, cin=0, sel=0, start pulse -> done at cycle 5; sum=6, cout=0, ovf=0, zero=0; busy high cycles 1-4.
- Same operands with sel=1 -> sum=4, cout=1, ovf=0. Then a=0, b=0, sel=1 -> sum=0, zero=1, cout=1.
- a=1, b=5, sel=1 -> sum=8'hFC, cout=0, ovf=0. Then a=8'h7F, b=1, sel=0 -> sum=8'h80, ovf=1, cout=0.
- Back-to-back: start held high through DONE with a new operand pair -> second RUN begins with no IDLE cycle. start pulses during RUN are ignored, and sum is unchanged until the proper done.
- rst_n driven low in cycle 2 of RUN -> busy, done and sum read 0 immediately, no done pulse follows, and the next start computes correctly.
- WIDTH=4, DIGIT=1: run the legacy set 5±1, 0±0, 2±2, 1±5 -> sums 6/4, 0/0, 4/0, 6/C.
  - done arrives 5 cycles after start.
  - cout is 1 for every subtract except 1-5, where it is 0.
